// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO; results computed at start, committed after N cycles.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles for mult/div; mthi/mtlo write HI/LO at the accepting edge.
// Backpressure: busy is registered; start while busy is dropped, so the hazard unit stalls on start|busy.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mf_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_wr;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_signed;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        b_safe;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        q_res;
    logic [31:0]        r_res;

    assign prod_s = $signed(rs_val) * $signed(rt_val);
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    always_comb begin
        div_signed = (md_op == 3'd2);
        a_mag      = (div_signed && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
        b_mag      = (div_signed && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
        b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        q_res      = (div_signed && (rs_val[31] ^ rt_val[31])) ? (32'd0 - q_mag) : q_mag;
        r_res      = (div_signed && rs_val[31]) ? (32'd0 - r_mag) : r_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (md_op)
                            3'd0, 3'd1: begin
                                pend_hi <= (md_op == 3'd0) ? prod_s[63:32] : prod_u[63:32];
                                pend_lo <= (md_op == 3'd0) ? prod_s[31:0]  : prod_u[31:0];
                                pend_wr <= 1'b1;
                                cnt     <= CW'(MULT_CYCLES);
                                busy    <= 1'b1;
                                state   <= RUN;
                            end
                            3'd2, 3'd3: begin
                                pend_hi <= r_res;
                                pend_lo <= q_res;
                                // Divide by zero still runs the full latency but leaves HI/LO alone.
                                pend_wr <= (rt_val != 32'd0);
                                cnt     <= CW'(DIV_CYCLES);
                                busy    <= 1'b1;
                                state   <= RUN;
                            end
                            3'd4:    hi <= rs_val;
                            3'd5:    lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign md_out = mf_sel ? hi : lo;

endmodule
